// File: rtl/dii_pkg.sv
// DII debug-ring shared definitions.
// Flit geometry, packet classes, header indices, packetizer states.
package dii_pkg;

  localparam int FLIT_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  localparam logic [1:0] PKT_REG_REQ  = 2'b00;
  localparam logic [1:0] PKT_REG_RESP = 2'b01;
  localparam logic [1:0] PKT_EVENT    = 2'b10;

  localparam int HDR_DEST  = 0;
  localparam int HDR_SRC   = 1;
  localparam int HDR_FLAGS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEST,
    S_SRC,
    S_FLAGS,
    S_PAYLOAD
  } pk_state_t;

endpackage

// File: rtl/dii_event_packetizer.sv
// Event-to-DII packetizer feeding one local port of the debug ring.
// Emits dest/src/flags header flits, then up to MAX_PAYLOAD payload flits.
import dii_pkg::*;

module dii_event_packetizer #(
  parameter int         FLIT_WIDTH  = dii_pkg::FLIT_WIDTH,
  parameter int         MAX_PAYLOAD = 8,
  parameter logic [1:0] PKT_TYPE    = PKT_EVENT,
  localparam int        LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [9:0]                      id,
  input  logic                            event_valid,
  output logic                            event_ready,
  input  logic [9:0]                      event_dest,
  input  logic [3:0]                      event_subtype,
  input  logic [LW-1:0]                   event_len,
  input  logic [MAX_PAYLOAD*FLIT_WIDTH-1:0] event_data,
  output logic [FLIT_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            out_first,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [15:0]                     pkt_count
);

  localparam logic [LW-1:0] MAXP = LW'(MAX_PAYLOAD);

  pk_state_t state_q, state_d;

  logic [9:0]                        id_q;
  logic [9:0]                        dest_q;
  logic [3:0]                        sub_q;
  logic [LW-1:0]                     len_q;
  logic [LW-1:0]                     idx_q;
  logic [MAX_PAYLOAD*FLIT_WIDTH-1:0] data_q;

  logic [LW-1:0]         len_in;
  logic [FLIT_WIDTH-1:0] flags;
  logic [FLIT_WIDTH-1:0] word;
  logic                  accept;
  logic                  done;
  logic                  pay_last;

  assign len_in = (event_len > MAXP) ? MAXP : event_len;
  assign word   = data_q[int'(idx_q)*FLIT_WIDTH +: FLIT_WIDTH];
  assign accept = event_valid & event_ready;
  assign pay_last = (idx_q == len_q - LW'(1));

  // Flags flit: class in the top two bits, subtype in the low nibble.
  always_comb begin
    flags = '0;
    flags[FLIT_WIDTH-1 -: 2] = PKT_TYPE;
    flags[3:0] = sub_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and flit outputs, decoded from registered state only.
  always_comb begin
    state_d     = state_q;
    out_valid   = 1'b0;
    out_first   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    event_ready = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        event_ready = rst;
        if (event_valid) state_d = S_DEST;
      end
      S_DEST: begin
        out_valid = 1'b1;
        out_first = 1'b1;
        out_data  = FLIT_WIDTH'(dest_q);
        if (out_ready) state_d = S_SRC;
      end
      S_SRC: begin
        out_valid = 1'b1;
        out_data  = FLIT_WIDTH'(id_q);
        if (out_ready) state_d = S_FLAGS;
      end
      S_FLAGS: begin
        out_valid = 1'b1;
        out_data  = flags;
        out_last  = (len_q == '0);
        if (out_ready) begin
          if (len_q == '0) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = word;
        out_last  = pay_last;
        if (out_ready && pay_last) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Event capture, payload index and completed-packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q      <= '0;
      dest_q    <= '0;
      sub_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      pkt_count <= '0;
    end else begin
      if (accept) begin
        id_q   <= id;
        dest_q <= event_dest;
        sub_q  <= event_subtype;
        len_q  <= len_in;
        data_q <= event_data;
        idx_q  <= '0;
      end else if (state_q == S_PAYLOAD && out_ready) begin
        idx_q <= idx_q + LW'(1);
      end
      if (done) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dii_event_packetizer.sv
// Bench for dii_event_packetizer: table of events, flit scoreboard,
// plus back-to-back and mid-packet reset sequences.
module tb_dii_event_packetizer;

  logic         clk;
  logic         rst;
  logic [9:0]   id;
  logic         event_valid;
  logic         event_ready;
  logic [9:0]   event_dest;
  logic [3:0]   event_subtype;
  logic [3:0]   event_len;
  logic [127:0] event_data;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic         out_ready;
  logic [15:0]  pkt_count;

  dii_event_packetizer dut (
    .clk(clk),
    .rst(rst),
    .id(id),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_dest(event_dest),
    .event_subtype(event_subtype),
    .event_len(event_len),
    .event_data(event_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last(out_last),
    .out_ready(out_ready),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        f;
    logic        l;
  } flit_t;

  typedef struct {
    logic [9:0]   id;
    logic [9:0]   dest;
    logic [3:0]   sub;
    logic [3:0]   len;
    logic [127:0] data;
    bit           tog;
    int           nflit;
  } vec_t;

  flit_t sbq[$];
  vec_t  vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pkt_seen = 0;
  int flits_cur = 0;
  int last_nflit = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int acc_cyc = 0;
  int exp_cnt = 0;
  bit tog_mode = 0;
  bit hold_v = 0;
  flit_t hd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (tog_mode) #1 out_ready = ~out_ready;

  // Reference packet for one event: three headers, then clamped payload.
  task automatic push_model(input vec_t v);
    int n;
    flit_t e;
    n = (v.len > 4'd8) ? 8 : int'(v.len);
    e.d = {6'b0, v.dest}; e.f = 1; e.l = 0; sbq.push_back(e);
    e.d = {6'b0, v.id};   e.f = 0; e.l = 0; sbq.push_back(e);
    e.d = {2'b10, 10'b0, v.sub}; e.f = 0; e.l = (n == 0); sbq.push_back(e);
    for (int k = 0; k < n; k++) begin
      e.d = v.data[k*16 +: 16];
      e.f = 0;
      e.l = (k == n - 1);
      sbq.push_back(e);
    end
  endtask

  // Flit monitor: scoreboard compare, hold-stability, ready exclusion.
  always @(negedge clk) begin
    flit_t e;
    if (!rst) begin
      hold_v = 0;
      flits_cur = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hd.d));
        chk("hold_first", 32'(out_first), 32'(hd.f));
        chk("hold_last", 32'(out_last), 32'(hd.l));
      end
      chk("ready_excl", 32'(event_ready), 32'(!out_valid));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("extra_flit", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("flit_data", 32'(out_data), 32'(e.d));
          chk("flit_first", 32'(out_first), 32'(e.f));
          chk("flit_last", 32'(out_last), 32'(e.l));
        end
        flits_cur++;
        if (out_first) first_cyc = cyc + 1;
        if (out_last) begin
          last_cyc = cyc + 1;
          last_nflit = flits_cur;
          flits_cur = 0;
          pkt_seen++;
        end
      end
      hold_v = out_valid && !out_ready;
      hd.d = out_data;
      hd.f = out_first;
      hd.l = out_last;
    end
  end

  task automatic drive(input vec_t v);
    id = v.id;
    event_dest = v.dest;
    event_subtype = v.sub;
    event_len = v.len;
    event_data = v.data;
  endtask

  task automatic wait_accept(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!event_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = event_ready;
    chk("accept_timeout", 32'(event_ready), 32'd1);
  endtask

  task automatic wait_pkts(input int target);
    int n;
    n = 0;
    while (pkt_seen < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", 32'(pkt_seen >= target), 32'd1);
  endtask

  task automatic run_pkt(input vec_t v);
    int base;
    bit ok;
    base = pkt_seen;
    drive(v);
    tog_mode = v.tog;
    event_valid = 1;
    wait_accept(ok);
    push_model(v);
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1 event_valid = 0;
    wait_pkts(base + 1);
    #1 tog_mode = 0;
    #1 out_ready = 1;
    exp_cnt++;
    chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
    chk("nflit", 32'(last_nflit), 32'(v.nflit));
    if (!v.tog) begin
      chk("latency", 32'(first_cyc), 32'(acc_cyc + 1));
      chk("consecutive", 32'(last_cyc - first_cyc), 32'(v.nflit - 1));
    end
  endtask

  function automatic logic [127:0] words(input logic [15:0] base,
                                         input logic [15:0] step);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = base + 16'(k) * step;
    return d;
  endfunction

  initial begin
    vec_t a, b;
    bit ok;
    int base;

    vecs[0] = '{10'd3, 10'h005, 4'h1, 4'd2, 128'h0, 0, 5};
    vecs[0].data[31:0] = 32'hBBBB_AAAA;
    vecs[1] = '{10'd0, 10'h3FF, 4'h0, 4'd0, 128'h0, 0, 3};
    vecs[2] = vecs[0];
    vecs[2].tog = 1;
    vecs[3] = '{10'h2A5, 10'h155, 4'hF, 4'd15, 128'h0, 0, 11};
    vecs[3].data = words(16'h1000, 16'h0111);
    vecs[4] = '{10'd1, 10'd2, 4'h7, 4'd8, 128'h0, 1, 11};
    vecs[4].data = words(16'hC000, 16'h0001);
    vecs[5] = '{10'h3FF, 10'h000, 4'hA, 4'd1, 128'h0, 0, 4};
    vecs[5].data[15:0] = 16'h5A5A;

    rst = 0;
    out_ready = 1;
    event_valid = 0;
    drive(vecs[0]);
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_first", 32'(out_first), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_ready", 32'(event_ready), 32'd0);
    #20 rst = 1;
    @(posedge clk);
    #1 chk("idle_ready", 32'(event_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_pkt(vecs[i]);

    // Back-to-back events with valid held high.
    a = vecs[0];
    b = vecs[5];
    base = pkt_seen;
    @(posedge clk);
    #1 drive(a);
    event_valid = 1;
    wait_accept(ok);
    push_model(a);
    @(posedge clk);
    #1 drive(b);
    wait_accept(ok);
    push_model(b);
    chk("b2b_accept", 32'(cyc + 1), 32'(last_cyc + 1));
    @(posedge clk);
    #1 event_valid = 0;
    wait_pkts(base + 2);
    #2;
    exp_cnt += 2;
    chk("b2b_count", 32'(pkt_count), 32'(exp_cnt));
    chk("b2b_sbq", 32'(sbq.size()), 32'd0);

    // Reset in the middle of the payload (index 1 on the bus).
    a = vecs[4];
    a.tog = 0;
    @(posedge clk);
    #1 drive(a);
    event_valid = 1;
    wait_accept(ok);
    push_model(a);
    @(posedge clk);
    #1 event_valid = 0;
    for (int n = 0; n < 50 && flits_cur < 4; n++) @(posedge clk);
    chk("mid_reached", 32'(flits_cur), 32'd4);
    #2 rst = 0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_first", 32'(out_first), 32'd0);
    chk("mid_last", 32'(out_last), 32'd0);
    chk("mid_data", 32'(out_data), 32'd0);
    chk("mid_count", 32'(pkt_count), 32'd0);
    chk("mid_ready", 32'(event_ready), 32'd0);
    sbq.delete();
    exp_cnt = 0;
    @(negedge clk);
    #2 rst = 1;
    @(posedge clk);
    #1;
    chk("post_ready", 32'(event_ready), 32'd1);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_count", 32'(pkt_count), 32'd0);
    run_pkt(vecs[0]);
    chk("post_sbq", 32'(sbq.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dii_event_packetizer.md
Name: dii_event_packetizer

Overview:
- Turns one-shot debug events from a module (trace or status words) into DII packets and drives them into one local input port of the debug ring.
- Sits directly upstream of the ring: its flit output connects to one port slice of the ring's module-to-router channel.
- Builds the header flits (destination, source, flags/type) itself and streams up to MAX_PAYLOAD payload flits.
- Fully backpressured: no event is ever dropped.

Parameters:
- FLIT_WIDTH, 16, width of one DII flit.
- MAX_PAYLOAD, 8, maximum payload flits per packet (1..64).
- PKT_TYPE, 2'b10, packet class placed in flags flit bits [15:14] (event class).

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- id  input  10  own ring address, sampled at event accept.
- event_valid  input  1  event offered.
- event_ready  output  1  event accepted when valid&ready.
- event_dest  input  10  destination address.
- event_subtype  input  4  placed in flags flit bits [3:0].
- event_len  input  clog2(MAX_PAYLOAD+1)  payload flit count, 0 allowed.
- event_data  input  MAX_PAYLOAD*FLIT_WIDTH  payload; word k in bits [k*16+:16], word 0 sent first.
- out_data  output  FLIT_WIDTH  flit to ring.
- out_valid  output  1  flit valid.
- out_first  output  1  first flit of packet.
- out_last  output  1  last flit of packet.
- out_ready  input  1  ring accepts flit.
- pkt_count  output  16  packets completed, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0, out_first=0, out_last=0, out_data=0, pkt_count=0, event_ready=0 while asserted. Event and payload registers are cleared.
- Mid-packet reset abandons the packet; no further flits are emitted. The ring end is responsible for discarding the partial packet.
- FSM states: IDLE -> DEST -> SRC -> FLAGS -> PAYLOAD -> IDLE.
- IDLE:
  - event_ready=1, out_valid=0.
  - On event_valid, latch id, dest, subtype, data and len_eff = min(event_len, MAX_PAYLOAD); go to DEST.
- DEST: out_data={6'b0,dest}, out_first=1.
- SRC: out_data={6'b0,id}.
- FLAGS: out_data={PKT_TYPE,10'b0,subtype}; out_last=1 iff len_eff==0.
- PAYLOAD: out_data=word[idx], idx counts from 0; out_last=1 iff idx==len_eff-1.
- Every non-IDLE state drives out_valid=1 and advances only on out_valid&out_ready.
- While out_ready=0, out_data, out_first and out_last hold stable.
- Last-flit handshake: pkt_count increments and the FSM returns to IDLE.
- event_ready is 0 in all non-IDLE states, so back-to-back events cost one IDLE cycle between packets.
- Latency: event accepted in cycle N gives DEST flit valid in cycle N+1. Minimum packet duration is 3+len_eff cycles plus one IDLE cycle.
- event_len > MAX_PAYLOAD is clamped silently to MAX_PAYLOAD.
- All outputs are registered or decoded from registered state only. There is no combinational path from out_ready to out_valid or out_data.
- pkt_count wraps without saturation.

Decomposition:
- Shared package dii_pkg holds:
  - FLIT_WIDTH and the address width (10).
  - Packet class codes (event=2'b10, register access codes).
  - Header flit index constants (DEST=0, SRC=1, FLAGS=2).
  - The FSM state enum.
- No sub-module: a single module with the FSM, payload register and index counter.

Test Plan:
- id=3, dest=0x005, subtype=4'h1, len=2, data words 0xAAAA,0xBBBB, out_ready=1 -> flits 0x0005(first), 0x0003, 0x8001, 0xAAAA, 0xBBBB(last) in 5 consecutive cycles starting 1 cycle after accept; pkt_count=1.
- len=0, dest=0x3FF, id=0 -> 3 flits 0x03FF(first), 0x0000, 0x8000 with last on flags flit.
- Same as first scenario but out_ready toggled 0/1 every cycle -> identical flit sequence; data/first/last stable while ready=0; event_ready=0 throughout.
- event_len=15 with MAX_PAYLOAD=8 -> exactly 8 payload flits, last on word 7.
- Two events back-to-back with event_valid held high -> second accepted one cycle after first last-flit handshake; no flits lost or duplicated; pkt_count=2.
- rst pulsed low during PAYLOAD idx=1 -> out_valid=0 immediately (async); after release event_ready=1, pkt_count=0, next event produces a clean packet.
